// File: rtl/arm_pkg.sv
// arm_pkg: shared types and register indices for the ARM execute-to-writeback slice.
package arm_pkg;
    typedef enum logic {IDLE, WAIT} mem_state_t;
    localparam logic [3:0] LR_IDX = 4'd14;
    localparam logic [3:0] PC_IDX = 4'd15;
    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pc_src;
        logic branch_link;
    } ctrl_t;
endpackage

// File: rtl/mem_to_wb_reg.sv
// mem_to_wb_reg: Memory-to-Writeback pipeline register; a stalled Memory stage hands Writeback a bubble.
module mem_to_wb_reg
    import arm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  ctrl_t       ctrl_m,
    input  logic [31:0] alu_out_m,
    input  logic [31:0] read_data,
    input  logic [31:0] pcplus4_m,
    input  logic [3:0]  wa3_m,
    output ctrl_t       ctrl_w,
    output logic [31:0] alu_out_w,
    output logic [31:0] read_data_w,
    output logic [31:0] pcplus4_w,
    output logic [3:0]  wa3_w
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || stall) begin
            ctrl_w      <= '0;
            alu_out_w   <= '0;
            read_data_w <= '0;
            pcplus4_w   <= '0;
            wa3_w       <= '0;
        end else begin
            ctrl_w      <= ctrl_m;
            alu_out_w   <= alu_out_m;
            read_data_w <= read_data;
            pcplus4_w   <= pcplus4_m;
            wa3_w       <= wa3_m;
        end
    end
endmodule

// File: rtl/exe_to_wb_datapath.sv
// exe_to_wb_datapath: Execute->Memory->Writeback back half of the pipeline with a single-outstanding
// data-memory sequencer, watchdog and register-file write port.
module exe_to_wb_datapath
    import arm_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validE,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WA3E,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        MemtoRegE,
    input  logic        PCSrcE,
    input  logic        branchLinkE,
    input  logic [31:0] PCPLUS4E,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [31:0] ALUOutM,
    output logic [3:0]  WA3M,
    output logic        RegWriteM,
    output logic [31:0] ResultW,
    output logic [3:0]  WA3W,
    output logic        RegWriteW,
    output logic        WE3,
    output logic [3:0]  A3,
    output logic [31:0] WD3,
    output logic        PCSrcW,
    output logic        bus_err
);
    localparam int WW = $clog2(TIMEOUT + 1);
    mem_state_t  state;
    logic [WW-1:0] wdog;
    logic        valid_m, mem_m, timeout, done;
    ctrl_t       ctrl_e, ctrl_m, ctrl_w;
    logic [31:0] write_data_m, pcplus4_m, alu_out_w, read_data_w, pcplus4_w, read_data;
    assign ctrl_e = validE ? ctrl_t'{RegWriteE, MemWriteE, MemtoRegE, PCSrcE, branchLinkE} : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_m      <= 1'b0;
            ctrl_m       <= '0;
            ALUOutM      <= '0;
            write_data_m <= '0;
            pcplus4_m    <= '0;
            WA3M         <= '0;
        end else if (!StallM) begin
            valid_m      <= validE;
            ctrl_m       <= ctrl_e;
            ALUOutM      <= validE ? ALUResultE : '0;
            write_data_m <= validE ? WriteDataE : '0;
            pcplus4_m    <= validE ? PCPLUS4E : '0;
            WA3M         <= validE ? WA3E : '0;
        end
    end
    assign mem_m = valid_m & (ctrl_m.mem_to_reg | ctrl_m.mem_write);
    // wdog counts WAIT cycles already spent, so the TIMEOUT-th WAIT cycle is the forced completion
    assign timeout = (state == WAIT) && (wdog == WW'(TIMEOUT - 1));
    assign done = (state == WAIT) && (dmem_rvalid || timeout);
    assign StallM = mem_m & ~done;
    assign dmem_req = (state == IDLE) & mem_m;
    assign dmem_we = ctrl_m.mem_write;
    assign dmem_addr = ALUOutM;
    assign dmem_wdata = write_data_m;
    assign RegWriteM = ctrl_m.reg_write;
    assign read_data = (state == WAIT && dmem_rvalid) ? dmem_rdata : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wdog    <= '0;
            bus_err <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (mem_m) begin
                    state <= WAIT;
                    wdog  <= '0;
                end
            end else if (done) begin
                state <= IDLE;
            end else begin
                wdog <= wdog + WW'(1);
            end
            if (timeout && !dmem_rvalid) bus_err <= 1'b1;
        end
    end
    mem_to_wb_reg u_m2w (
        .clk        (clk),
        .reset      (reset),
        .stall      (StallM),
        .ctrl_m     (ctrl_m),
        .alu_out_m  (ALUOutM),
        .read_data  (read_data),
        .pcplus4_m  (pcplus4_m),
        .wa3_m      (WA3M),
        .ctrl_w     (ctrl_w),
        .alu_out_w  (alu_out_w),
        .read_data_w(read_data_w),
        .pcplus4_w  (pcplus4_w),
        .wa3_w      (WA3W)
    );
    assign ResultW = ctrl_w.branch_link ? pcplus4_w : ctrl_w.mem_to_reg ? read_data_w : alu_out_w;
    assign WD3 = ResultW;
    assign A3 = ctrl_w.branch_link ? LR_IDX : WA3W;
    assign WE3 = ctrl_w.reg_write | ctrl_w.branch_link;
    assign RegWriteW = ctrl_w.reg_write;
    assign PCSrcW = ctrl_w.pc_src | (WE3 && A3 == PC_IDX);
endmodule

// File: tb/tb_exe_to_wb_datapath.sv
// tb_exe_to_wb_datapath: directed vector table plus hand-written memory, timeout and reset sequences.
module tb_exe_to_wb_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        validE = 1'b0;
    logic [31:0] ALUResultE = '0, WriteDataE = '0, PCPLUS4E = '0;
    logic [3:0]  WA3E = '0;
    logic        RegWriteE = 1'b0, MemWriteE = 1'b0, MemtoRegE = 1'b0, PCSrcE = 1'b0, branchLinkE = 1'b0;
    logic        dmem_req, dmem_we, dmem_rvalid = 1'b0;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
    logic        StallM, RegWriteM, RegWriteW, WE3, PCSrcW, bus_err;
    logic [31:0] ALUOutM, ResultW, WD3;
    logic [3:0]  WA3M, WA3W, A3;
    int checks = 0;
    int errors = 0;

    exe_to_wb_datapath #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .validE(validE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .WA3E(WA3E), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .branchLinkE(branchLinkE), .PCPLUS4E(PCPLUS4E),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .StallM(StallM),
        .ALUOutM(ALUOutM), .WA3M(WA3M), .RegWriteM(RegWriteM),
        .ResultW(ResultW), .WA3W(WA3W), .RegWriteW(RegWriteW),
        .WE3(WE3), .A3(A3), .WD3(WD3), .PCSrcW(PCSrcW), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic [3:0]  wa3;
        logic        rw, pcs, bl;
        logic [31:0] pc4;
        logic        exp_we;
        logic [3:0]  exp_a3;
        logic [31:0] exp_wd;
        logic        exp_pcs;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_e(input logic v, input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa3,
                           input logic rw, input logic mw, input logic m2r, input logic pcs, input logic bl,
                           input logic [31:0] pc4);
        validE = v; ALUResultE = alu; WriteDataE = wd; WA3E = wa3;
        RegWriteE = rw; MemWriteE = mw; MemtoRegE = m2r; PCSrcE = pcs; branchLinkE = bl; PCPLUS4E = pc4;
    endtask

    task automatic bubble;
        drive_e(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Memory op already sits in M; rvalid is pulsed in cycle rv_at (counted from the req cycle, -1 = never).
    task automatic run_mem(input int rv_at, input logic [31:0] data, output int reqs, output int stalls);
        reqs = 0;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            logic fin;
            dmem_rvalid = (c == rv_at);
            dmem_rdata = (c == rv_at) ? data : 32'h0;
            #1;
            reqs += int'(dmem_req);
            stalls += int'(StallM);
            fin = !StallM;
            step;
            if (fin) break;
        end
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        #1;
    endtask

    initial begin
        int reqs, stalls;
        vecs[0] = '{1'b1, 32'h0000_0005, 4'd3,  1'b1, 1'b0, 1'b0, 32'h0,     1'b1, 4'd3,  32'h0000_0005, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_1234, 4'd0,  1'b0, 1'b0, 1'b1, 32'h204,   1'b1, 4'd14, 32'h0000_0204, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_0009, 4'd7,  1'b1, 1'b0, 1'b0, 32'h0,     1'b0, 4'd0,  32'h0000_0000, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0080, 4'd15, 1'b1, 1'b1, 1'b0, 32'h0,     1'b1, 4'd15, 32'h0000_0080, 1'b1};
        vecs[4] = '{1'b1, 32'h0000_0055, 4'd2,  1'b0, 1'b0, 1'b0, 32'h0,     1'b0, 4'd2,  32'h0000_0055, 1'b0};

        #1 reset = 1'b0;
        step;
        step;
        chk("rst_req", {31'b0, dmem_req}, 32'h0);
        chk("rst_stall", {31'b0, StallM}, 32'h0);
        chk("rst_we3", {31'b0, WE3}, 32'h0);
        chk("rst_a3", {28'b0, A3}, 32'h0);
        chk("rst_wd3", WD3, 32'h0);
        chk("rst_buserr", {31'b0, bus_err}, 32'h0);
        @(negedge clk) reset = 1'b1;
        step;

        for (int i = 0; i < 5; i++) begin
            drive_e(vecs[i].valid, vecs[i].alu, 32'h0, vecs[i].wa3, vecs[i].rw, 1'b0, 1'b0,
                    vecs[i].pcs, vecs[i].bl, vecs[i].pc4);
            step;
            chk($sformatf("v%0d_stall", i), {31'b0, StallM}, 32'h0);
            bubble;
            step;
            chk($sformatf("v%0d_we3", i), {31'b0, WE3}, {31'b0, vecs[i].exp_we});
            chk($sformatf("v%0d_a3", i), {28'b0, A3}, {28'b0, vecs[i].exp_a3});
            chk($sformatf("v%0d_wd3", i), WD3, vecs[i].exp_wd);
            chk($sformatf("v%0d_pcsrc", i), {31'b0, PCSrcW}, {31'b0, vecs[i].exp_pcs});
        end

        // Load, rvalid three cycles after the request
        drive_e(1'b1, 32'h100, 32'h0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step;
        chk("ld_addr", dmem_addr, 32'h100);
        chk("ld_we", {31'b0, dmem_we}, 32'h0);
        bubble;
        run_mem(3, 32'hDEAD_BEEF, reqs, stalls);
        chk("ld_reqs", reqs, 1);
        chk("ld_stalls", stalls, 3);
        chk("ld_we3", {31'b0, WE3}, 32'h1);
        chk("ld_a3", {28'b0, A3}, 32'h4);
        chk("ld_wd3", WD3, 32'hDEAD_BEEF);

        // Back-to-back loads: the second request follows completion immediately
        drive_e(1'b1, 32'h300, 32'h0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step;
        drive_e(1'b1, 32'h304, 32'h0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        run_mem(1, 32'h1111_1111, reqs, stalls);
        chk("b2b_stalls1", stalls, 1);
        chk("b2b_wd3_1", WD3, 32'h1111_1111);
        chk("b2b_req2", {31'b0, dmem_req}, 32'h1);
        chk("b2b_addr2", dmem_addr, 32'h304);
        bubble;
        run_mem(1, 32'h2222_2222, reqs, stalls);
        chk("b2b_reqs2", reqs, 1);
        chk("b2b_a3_2", {28'b0, A3}, 32'h2);
        chk("b2b_wd3_2", WD3, 32'h2222_2222);
        chk("b2b_buserr", {31'b0, bus_err}, 32'h0);

        // Store that never completes: watchdog forces completion after 4 stall cycles
        drive_e(1'b1, 32'h200, 32'h0000_CAFE, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step;
        chk("st_req", {31'b0, dmem_req}, 32'h1);
        chk("st_we", {31'b0, dmem_we}, 32'h1);
        chk("st_wdata", dmem_wdata, 32'h0000_CAFE);
        bubble;
        run_mem(-1, 32'h0, reqs, stalls);
        chk("st_stalls", stalls, 4);
        chk("st_buserr", {31'b0, bus_err}, 32'h1);
        chk("st_we3", {31'b0, WE3}, 32'h0);
        drive_e(1'b1, 32'h77, 32'h0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step;
        bubble;
        step;
        chk("resume_we3", {31'b0, WE3}, 32'h1);
        chk("resume_wd3", WD3, 32'h77);
        chk("sticky_buserr", {31'b0, bus_err}, 32'h1);

        // Reset asserted during WAIT, then a late rvalid
        drive_e(1'b1, 32'h400, 32'h0, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        step;
        bubble;
        step;
        chk("wait_stall", {31'b0, StallM}, 32'h1);
        reset = 1'b0;
        #1;
        chk("arst_stall", {31'b0, StallM}, 32'h0);
        chk("arst_req", {31'b0, dmem_req}, 32'h0);
        chk("arst_we3", {31'b0, WE3}, 32'h0);
        chk("arst_aluoutm", ALUOutM, 32'h0);
        chk("arst_buserr", {31'b0, bus_err}, 32'h0);
        @(negedge clk) reset = 1'b1;
        step;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h0000_0999;
        step;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        step;
        chk("late_we3", {31'b0, WE3}, 32'h0);
        chk("late_wd3", WD3, 32'h0);
        chk("late_stall", {31'b0, StallM}, 32'h0);
        chk("late_req", {31'b0, dmem_req}, 32'h0);

        // rvalid in IDLE with an ALU op flowing
        drive_e(1'b1, 32'h66, 32'h0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h0000_0BAD;
        step;
        bubble;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        step;
        chk("idle_rv_wd3", WD3, 32'h66);
        chk("idle_rv_a3", {28'b0, A3}, 32'h6);
        chk("idle_rv_stall", {31'b0, StallM}, 32'h0);
        chk("idle_rv_req", {31'b0, dmem_req}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
